// File: rtl/shift_seq_pkg.sv
// Shared constants and encodings for the iterative shifter and its bench.
package shift_seq_pkg;

  localparam int DW = 16;

  // Operation encodings as presented on the Op input.
  typedef enum logic [1:0] {
    OP_ROL = 2'b00,  // rotate left
    OP_SLL = 2'b01,  // shift left logical
    OP_SRA = 2'b10,  // shift right arithmetic
    OP_SRL = 2'b11   // shift right logical
  } op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/mux2_1.sv
// Single-bit 2:1 multiplexer cell: y = sel ? b : a.
module mux2_1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/shift1_stage.sv
// Combinational one-position shifter built from mux2_1 cells.
// op[1] picks direction (0 = left, 1 = right); op[0] picks the fill bit:
// 0 feeds din[15] (rotate-left wrap or arithmetic sign), 1 feeds zero.
module shift1_stage
  import shift_seq_pkg::*;
(
  input  logic [DW-1:0] din,
  input  logic [1:0]    op,
  output logic [DW-1:0] dout
);

  logic          fill_s;
  logic [DW-1:0] left_s;
  logic [DW-1:0] right_s;

  // Both directions use din[15] as the non-zero fill, so one cell serves both.
  mux2_1 u_fill (
    .a   (din[DW-1]),
    .b   (1'b0),
    .sel (op[0]),
    .y   (fill_s)
  );

  assign left_s  = {din[DW-2:0], fill_s};
  assign right_s = {fill_s, din[DW-1:1]};

  for (genvar i = 0; i < DW; i++) begin : g_dir
    mux2_1 u_dir (
      .a   (left_s[i]),
      .b   (right_s[i]),
      .sel (op[1]),
      .y   (dout[i])
    );
  end

endmodule

// File: rtl/shift_seq.sv
// Iterative 16-bit shifter: one 1-bit shift of Out per clock for Cnt clocks,
// sequenced by an IDLE/SHIFT/DONE FSM. Busy and Done are registered.
module shift_seq
  import shift_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] In,
  input  logic [3:0]    Cnt,
  input  logic [1:0]    Op,
  input  logic          Start,
  output logic [DW-1:0] Out,
  output logic          Busy,
  output logic          Done
);

  state_e        state_r;
  state_e        state_nx_s;
  logic [DW-1:0] out_r;
  logic [DW-1:0] out_nx_s;
  logic [3:0]    rem_r;
  logic [3:0]    rem_nx_s;
  op_e           op_r;
  op_e           op_nx_s;
  logic          busy_r;
  logic          done_r;
  logic [DW-1:0] shifted_s;

  shift1_stage u_stage (
    .din  (out_r),
    .op   (op_r),
    .dout (shifted_s)
  );

  // Next-state, operand capture and shift-count decrement.
  always_comb begin
    state_nx_s = state_r;
    out_nx_s   = out_r;
    rem_nx_s   = rem_r;
    op_nx_s    = op_r;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          out_nx_s   = In;
          rem_nx_s   = Cnt;
          op_nx_s    = op_e'(Op);
          state_nx_s = (Cnt != 4'd0) ? ST_SHIFT : ST_DONE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        out_nx_s = shifted_s;
        rem_nx_s = rem_r - 4'd1;
        // remaining is >= 1 here, so the decrement never wraps.
        if (rem_r == 4'd1) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      out_r   <= 16'h0000;
      rem_r   <= 4'd0;
      op_r    <= OP_ROL;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      out_r   <= out_nx_s;
      rem_r   <= rem_nx_s;
      op_r    <= op_nx_s;
      busy_r  <= (state_nx_s != ST_IDLE);
      done_r  <= (state_nx_s == ST_DONE);
    end
  end

  assign Out  = out_r;
  assign Busy = busy_r;
  assign Done = done_r;

endmodule

// File: tb/tb_shift_seq.sv
// Directed self-checking bench for shift_seq.
module tb_shift_seq;
  import shift_seq_pkg::*;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] In;
  logic [3:0]    Cnt;
  logic [1:0]    Op;
  logic          Start;
  logic [DW-1:0] Out;
  logic          Busy;
  logic          Done;

  int tests_run    = 0;
  int tests_failed = 0;

  shift_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .In    (In),
    .Cnt   (Cnt),
    .Op    (Op),
    .Start (Start),
    .Out   (Out),
    .Busy  (Busy),
    .Done  (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, scramble inputs after acceptance, and check result,
  // latency, busy duration, single-cycle Done and result hold.
  task automatic run_op(input string tag, input logic [15:0] din, input logic [3:0] cnt,
                        input logic [1:0] op, input logic [15:0] exp);
    int lat;
    int busy_n;
    @(negedge clk);
    In = din; Cnt = cnt; Op = op; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    In = 16'($urandom()); Cnt = 4'($urandom()); Op = 2'($urandom());
    lat = 0; busy_n = 0;
    while (Done !== 1'b1 && lat < 40) begin
      if (Busy === 1'b1) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    if (Busy === 1'b1) busy_n++;
    check_eq({tag, "/latency"}, lat, 32'(cnt));
    check_eq({tag, "/out"}, 32'(Out), 32'(exp));
    check_eq({tag, "/busy_cycles"}, busy_n, 32'(cnt) + 32'd1);
    @(posedge clk); #1;
    check_eq({tag, "/done_pulse"}, 32'(Done), 32'd0);
    check_eq({tag, "/busy_after"}, 32'(Busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq({tag, "/hold"}, 32'(Out), 32'(exp));
  endtask

  initial begin
    int dones;
    rst_n = 1'b0; Start = 1'b0; In = 16'h0000; Cnt = 4'd0; Op = 2'b00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst/out",  32'(Out),  32'h0);
    check_eq("rst/busy", 32'(Busy), 32'd0);
    check_eq("rst/done", 32'(Done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Functional vectors (first one is the first Start after reset)
    run_op("srl1",   16'h8001, 4'd1,  2'b11, 16'h4000);
    run_op("rol4",   16'h8001, 4'd4,  2'b00, 16'h0018);
    run_op("sll8",   16'h00FF, 4'd8,  2'b01, 16'hFF00);
    run_op("sra15",  16'h8000, 4'd15, 2'b10, 16'hFFFF);
    run_op("srl15",  16'h8000, 4'd15, 2'b11, 16'h0001);
    run_op("cnt0a",  16'h1234, 4'd0,  2'b10, 16'h1234);
    run_op("cnt0b",  16'h1234, 4'd0,  2'b00, 16'h1234);
    run_op("rol15",  16'hA5A5, 4'd15, 2'b00, 16'hD2D2);
    run_op("sra_pos",16'h4000, 4'd2,  2'b10, 16'h1000);
    run_op("sll1",   16'hC000, 4'd1,  2'b01, 16'h8000);

    // Start while busy must be ignored, exactly one Done
    @(negedge clk);
    In = 16'h00FF; Cnt = 4'd8; Op = 2'b01; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    dones = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 3) begin
        Start = 1'b1; In = 16'hFFFF; Cnt = 4'd1; Op = 2'b00;
      end
      if (c == 4 || c == 10) Start = 1'b0;
      @(posedge clk); #1;
      if (Done === 1'b1) begin
        dones++;
        check_eq("ign/done_cycle", c, 32'd8);
        check_eq("ign/out", 32'(Out), 32'hFF00);
        Start = 1'b1;
      end
    end
    Start = 1'b0;
    check_eq("ign/done_count", dones, 32'd1);
    check_eq("ign/hold", 32'(Out), 32'hFF00);
    check_eq("ign/idle", 32'(Busy), 32'd0);

    // Reset in the third SHIFT cycle aborts with no Done
    @(negedge clk);
    In = 16'h00FF; Cnt = 4'd8; Op = 2'b01; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort/out",  32'(Out),  32'h0);
    check_eq("abort/busy", 32'(Busy), 32'd0);
    check_eq("abort/done", 32'(Done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (Done === 1'b1) dones++;
    end
    check_eq("abort/no_done", dones, 32'd0);
    run_op("post_rst", 16'h8001, 4'd4, 2'b00, 16'h0018);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
